control_sequencer: RTL and testbench

//  Hardwired control unit for the phase-2 datapath; replaces the hand-driven T-state bench stimulus.

---
 rtl/cpu_ctrl_pkg.sv | 150 +++++++++++++++
 rtl/ctrl_mem_timer.sv | 37 +++
 rtl/control_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// enable/busSelect bit map, sequencer states and the registered output bundle.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BR   = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD    = 5'd3;
    localparam logic [4:0] ALU_SUB    = 5'd4;
    localparam logic [4:0] ALU_AND    = 5'd5;
    localparam logic [4:0] ALU_OR     = 5'd6;
    localparam logic [4:0] ALU_SHR    = 5'd7;
    localparam logic [4:0] ALU_SHRA   = 5'd8;
    localparam logic [4:0] ALU_SHL    = 5'd9;
    localparam logic [4:0] ALU_ROR    = 5'd10;
    localparam logic [4:0] ALU_ROL    = 5'd11;
    localparam logic [4:0] ALU_INC_PC = 5'd14;
    localparam logic [4:0] ALU_MUL    = 5'd15;
    localparam logic [4:0] ALU_DIV    = 5'd16;
    localparam logic [4:0] ALU_NEG    = 5'd17;
    localparam logic [4:0] ALU_NOT    = 5'd18;

    // Bits 0-15 of enable belong to the general registers via select/encode.
    localparam int unsigned EN_HI   = 16;
    localparam int unsigned EN_LO   = 17;
    localparam int unsigned EN_Z    = 18;
    localparam int unsigned EN_PC   = 20;
    localparam int unsigned EN_MDR  = 21;
    localparam int unsigned EN_Y    = 23;
    localparam int unsigned EN_IR   = 24;
    localparam int unsigned EN_MAR  = 25;
    localparam int unsigned EN_OUTP = 26;
    localparam int unsigned EN_CON  = 27;

    localparam int unsigned BS_INP = 0;
    localparam int unsigned BS_HI  = 16;
    localparam int unsigned BS_LO  = 17;
    localparam int unsigned BS_ZHI = 18;
    localparam int unsigned BS_ZLO = 19;
    localparam int unsigned BS_PC  = 20;
    localparam int unsigned BS_MDR = 21;
    localparam int unsigned BS_C   = 23;

    typedef enum logic [3:0] {
        RESET_ST,
        T0, T1, T2, T3, T4, T5, T6, T7,
        HALT,
        STEP_WAIT
    } state_e;

    typedef enum logic [3:0] {
        C_LD, C_LDI, C_ST, C_ALU, C_ALUI, C_UNARY, C_MULDIV,
        C_BR, C_JR, C_JAL, C_IN, C_OUT, C_MFHI, C_MFLO,
        C_HALT, C_NOP
    } op_class_e;

    typedef struct packed {
        logic [31:0] enable;
        logic [31:0] bus_sel;
        logic        gra;
        logic        grb;
        logic        grc;
        logic        rin;
        logic        rout;
        logic        baout;
        logic        md_read;
        logic        read_ram;
        logic        write_ram;
        logic [4:0]  alu;
    } ctrl_out_t;

    function automatic logic [31:0] bit32(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e c;
        c = C_NOP;
        case (op)
            OP_LD:   c = C_LD;
            OP_LDI:  c = C_LDI;
            OP_ST:   c = C_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
                     c = C_ALU;
            OP_ADDI, OP_ANDI, OP_ORI:
                     c = C_ALUI;
            OP_NEG, OP_NOT: c = C_UNARY;
            OP_MUL, OP_DIV: c = C_MULDIV;
            OP_BR:   c = C_BR;
            OP_JR:   c = C_JR;
            OP_JAL:  c = C_JAL;
            OP_IN:   c = C_IN;
            OP_OUT:  c = C_OUT;
            OP_MFHI: c = C_MFHI;
            OP_MFLO: c = C_MFLO;
            OP_HALT: c = C_HALT;
            default: c = C_NOP;
        endcase
        return c;
    endfunction

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        logic [4:0] a;
        a = ALU_ADD;
        case (op)
            OP_SUB:          a = ALU_SUB;
            OP_AND, OP_ANDI: a = ALU_AND;
            OP_OR, OP_ORI:   a = ALU_OR;
            OP_SHR:          a = ALU_SHR;
            OP_SHRA:         a = ALU_SHRA;
            OP_SHL:          a = ALU_SHL;
            OP_ROR:          a = ALU_ROR;
            OP_ROL:          a = ALU_ROL;
            OP_MUL:          a = ALU_MUL;
            OP_DIV:          a = ALU_DIV;
            OP_NEG:          a = ALU_NEG;
            OP_NOT:          a = ALU_NOT;
            default:         a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Wait-cycle counter for RAM strobes: restarts at 0 on every state entry and
// saturates once the programmed number of extra cycles has elapsed.
module ctrl_mem_timer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic restart,
    output logic done
);

    localparam logic [1:0] LAST = 2'(MEM_WAIT);

    logic [1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == LAST);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer with registered Moore outputs.
// Optional single-step hold state enabled by CTRL_SINGLE_STEP_EN.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic [31:0] enable,
    output logic [31:0] busSelect,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        MD_Read,
    output logic        ReadRAM,
    output logic        WriteRAM,
    output logic [4:0]  Control_Signals,
    output logic        run
);

`ifdef CTRL_SINGLE_STEP_EN
    localparam state_e FIN_ST = STEP_WAIT;
`else
    localparam state_e FIN_ST = T0;
`endif

    state_e     state_q, state_d;
    logic [4:0] op_q, op_d;
    ctrl_out_t  out_q, out_d;
    logic       run_q, run_d;
    logic       restart;
    logic       done;
    op_class_e  cls_q, cls_d;
    logic       unused_ir;

    // Register fields are routed to select/encode logic elsewhere.
    assign unused_ir = ^ir[26:0];

    ctrl_mem_timer #(
        .MEM_WAIT (MEM_WAIT)
    ) u_timer (
        .clk     (clk),
        .clr     (clr),
        .restart (restart),
        .done    (done)
    );

    always_comb begin
        op_d    = (state_q == T2) ? ir[31:27] : op_q;
        cls_q   = op_class(op_q);
        state_d = state_q;
        unique case (state_q)
            RESET_ST: state_d = T0;
            T0:       state_d = T1;
            T1:       if (done) state_d = T2;
            T2:       state_d = T3;
            T3: begin
                unique case (cls_q)
                    C_HALT: state_d = HALT;
                    C_LD, C_LDI, C_ST, C_ALU, C_ALUI,
                    C_UNARY, C_MULDIV, C_BR, C_JAL:
                            state_d = T4;
                    default: state_d = FIN_ST;
                endcase
            end
            T4: begin
                unique case (cls_q)
                    C_UNARY, C_JAL: state_d = FIN_ST;
                    default:        state_d = T5;
                endcase
            end
            T5: begin
                unique case (cls_q)
                    C_LD, C_ST, C_MULDIV, C_BR: state_d = T6;
                    default:                    state_d = FIN_ST;
                endcase
            end
            T6: begin
                unique case (cls_q)
                    C_LD:    if (done) state_d = T7;
                    C_ST:    state_d = T7;
                    default: state_d = FIN_ST;
                endcase
            end
            T7: begin
                if (cls_q != C_ST || done) state_d = FIN_ST;
            end
            HALT: state_d = HALT;
`ifdef CTRL_SINGLE_STEP_EN
            STEP_WAIT: state_d = step ? T0 : STEP_WAIT;
`else
            STEP_WAIT: state_d = T0;
`endif
            default: state_d = T0;
        endcase
        restart = (state_d != state_q);
    end

    // Outputs are decoded for the state being entered and then registered.
    always_comb begin
        out_d = '0;
        cls_d = op_class(op_d);
        run_d = (state_d != HALT);
        unique case (state_d)
            T0: begin
                out_d.bus_sel = bit32(BS_PC);
                out_d.enable  = bit32(EN_MAR) | bit32(EN_Z);
                out_d.alu     = ALU_INC_PC;
            end
            T1: begin
                if (restart) begin
                    out_d.bus_sel = bit32(BS_ZLO);
                    out_d.enable  = bit32(EN_PC);
                end
                out_d.enable   = out_d.enable | bit32(EN_MDR);
                out_d.read_ram = 1'b1;
                out_d.md_read  = 1'b1;
            end
            T2: begin
                out_d.bus_sel = bit32(BS_MDR);
                out_d.enable  = bit32(EN_IR);
            end
            T3: begin
                unique case (cls_d)
                    C_LD, C_LDI, C_ST: begin
                        out_d.grb    = 1'b1;
                        out_d.baout  = 1'b1;
                        out_d.enable = bit32(EN_Y);
                    end
                    C_ALU, C_ALUI: begin
                        out_d.grb    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_Y);
                    end
                    C_UNARY: begin
                        out_d.grb    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.alu    = alu_code(op_d);
                        out_d.enable = bit32(EN_Z);
                    end
                    C_MULDIV: begin
                        out_d.gra    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_Y);
                    end
                    C_BR: begin
                        out_d.gra    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_CON);
                    end
                    C_JR: begin
                        out_d.gra    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_PC);
                    end
                    C_JAL: begin
                        out_d.bus_sel = bit32(BS_PC);
                        out_d.grb     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    C_IN: begin
                        out_d.bus_sel = bit32(BS_INP);
                        out_d.gra     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    C_OUT: begin
                        out_d.gra    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_OUTP);
                    end
                    C_MFHI: begin
                        out_d.bus_sel = bit32(BS_HI);
                        out_d.gra     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    C_MFLO: begin
                        out_d.bus_sel = bit32(BS_LO);
                        out_d.gra     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    default: ;
                endcase
            end
            T4: begin
                unique case (cls_d)
                    C_LD, C_LDI, C_ST: begin
                        out_d.bus_sel = bit32(BS_C);
                        out_d.alu     = ALU_ADD;
                        out_d.enable  = bit32(EN_Z);
                    end
                    C_ALU: begin
                        out_d.grc    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.alu    = alu_code(op_d);
                        out_d.enable = bit32(EN_Z);
                    end
                    C_ALUI: begin
                        out_d.bus_sel = bit32(BS_C);
                        out_d.alu     = alu_code(op_d);
                        out_d.enable  = bit32(EN_Z);
                    end
                    C_UNARY: begin
                        out_d.bus_sel = bit32(BS_ZLO);
                        out_d.gra     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    C_MULDIV: begin
                        out_d.grb    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.alu    = alu_code(op_d);
                        out_d.enable = bit32(EN_Z);
                    end
                    C_BR: begin
                        out_d.bus_sel = bit32(BS_PC);
                        out_d.enable  = bit32(EN_Y);
                    end
                    C_JAL: begin
                        out_d.gra    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_PC);
                    end
                    default: ;
                endcase
            end
            T5: begin
                unique case (cls_d)
                    C_LD, C_ST: begin
                        out_d.bus_sel = bit32(BS_ZLO);
                        out_d.enable  = bit32(EN_MAR);
                    end
                    C_LDI, C_ALU, C_ALUI: begin
                        out_d.bus_sel = bit32(BS_ZLO);
                        out_d.gra     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    C_MULDIV: begin
                        out_d.bus_sel = bit32(BS_ZLO);
                        out_d.enable  = bit32(EN_LO);
                    end
                    C_BR: begin
                        out_d.bus_sel = bit32(BS_C);
                        out_d.alu     = ALU_ADD;
                        out_d.enable  = bit32(EN_Z);
                    end
                    default: ;
                endcase
            end
            T6: begin
                unique case (cls_d)
                    C_LD: begin
                        out_d.read_ram = 1'b1;
                        out_d.md_read  = 1'b1;
                        out_d.enable   = bit32(EN_MDR);
                    end
                    C_ST: begin
                        out_d.gra    = 1'b1;
                        out_d.rout   = 1'b1;
                        out_d.enable = bit32(EN_MDR);
                    end
                    C_MULDIV: begin
                        out_d.bus_sel = bit32(BS_ZHI);
                        out_d.enable  = bit32(EN_HI);
                    end
                    C_BR: begin
                        if (con_ff) begin
                            out_d.bus_sel = bit32(BS_ZLO);
                            out_d.enable  = bit32(EN_PC);
                        end
                    end
                    default: ;
                endcase
            end
            T7: begin
                unique case (cls_d)
                    C_LD: begin
                        out_d.bus_sel = bit32(BS_MDR);
                        out_d.gra     = 1'b1;
                        out_d.rin     = 1'b1;
                    end
                    C_ST:    out_d.write_ram = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= RESET_ST;
            op_q    <= '0;
            out_q   <= '0;
            run_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            out_q   <= out_d;
            run_q   <= run_d;
        end
    end

    assign enable          = out_q.enable;
    assign busSelect       = out_q.bus_sel;
    assign Gra             = out_q.gra;
    assign Grb             = out_q.grb;
    assign Grc             = out_q.grc;
    assign Rin             = out_q.rin;
    assign Rout            = out_q.rout;
    assign BAout           = out_q.baout;
    assign MD_Read         = out_q.md_read;
    assign ReadRAM         = out_q.read_ram;
    assign WriteRAM        = out_q.write_ram;
    assign Control_Signals = out_q.alu;
    assign run             = run_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed cycle-by-cycle bench for control_sequencer (MEM_WAIT=1).
// Covers the CTRL_SINGLE_STEP_EN hold state when that macro is defined.
module tb_control_sequencer;

    localparam logic [31:0] E_HI   = 32'h0001_0000;
    localparam logic [31:0] E_LO   = 32'h0002_0000;
    localparam logic [31:0] E_Z    = 32'h0004_0000;
    localparam logic [31:0] E_PC   = 32'h0010_0000;
    localparam logic [31:0] E_MDR  = 32'h0020_0000;
    localparam logic [31:0] E_Y    = 32'h0080_0000;
    localparam logic [31:0] E_IR   = 32'h0100_0000;
    localparam logic [31:0] E_MAR  = 32'h0200_0000;
    localparam logic [31:0] E_CON  = 32'h0800_0000;

    localparam logic [31:0] B_ZHI  = 32'h0004_0000;
    localparam logic [31:0] B_ZLO  = 32'h0008_0000;
    localparam logic [31:0] B_PC   = 32'h0010_0000;
    localparam logic [31:0] B_MDR  = 32'h0020_0000;
    localparam logic [31:0] B_C    = 32'h0080_0000;

    localparam logic [31:0] F_GRA  = 32'h200;
    localparam logic [31:0] F_GRB  = 32'h100;
    localparam logic [31:0] F_GRC  = 32'h080;
    localparam logic [31:0] F_RIN  = 32'h040;
    localparam logic [31:0] F_ROUT = 32'h020;
    localparam logic [31:0] F_BA   = 32'h010;
    localparam logic [31:0] F_MDRD = 32'h008;
    localparam logic [31:0] F_RD   = 32'h004;
    localparam logic [31:0] F_WR   = 32'h002;
    localparam logic [31:0] F_RUN  = 32'h001;

    localparam logic [31:0] A_ADD = 32'd3;
    localparam logic [31:0] A_INC = 32'd14;
    localparam logic [31:0] A_MUL = 32'd15;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] ir;
    logic        con_ff;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step;
`endif
    logic [31:0] enable;
    logic [31:0] busSelect;
    logic        Gra, Grb, Grc, Rin, Rout, BAout;
    logic        MD_Read, ReadRAM, WriteRAM;
    logic [4:0]  Control_Signals;
    logic        run;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    control_sequencer #(
        .MEM_WAIT (1)
    ) dut (
        .clk             (clk),
        .clr             (clr),
        .ir              (ir),
        .con_ff          (con_ff),
`ifdef CTRL_SINGLE_STEP_EN
        .step            (step),
`endif
        .enable          (enable),
        .busSelect       (busSelect),
        .Gra             (Gra),
        .Grb             (Grb),
        .Grc             (Grc),
        .Rin             (Rin),
        .Rout            (Rout),
        .BAout           (BAout),
        .MD_Read         (MD_Read),
        .ReadRAM         (ReadRAM),
        .WriteRAM        (WriteRAM),
        .Control_Signals (Control_Signals),
        .run             (run)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] flags();
        return {22'd0, Gra, Grb, Grc, Rin, Rout, BAout,
                MD_Read, ReadRAM, WriteRAM, run};
    endfunction

    task automatic now_chk(input string tag, input logic [31:0] en,
                           input logic [31:0] bs, input logic [31:0] fl,
                           input logic [31:0] cs);
        check({tag, ".en"}, enable, en);
        check({tag, ".bs"}, busSelect, bs);
        check({tag, ".fl"}, flags(), fl);
        check({tag, ".cs"}, {27'd0, Control_Signals}, cs);
    endtask

    task automatic stp(input string tag, input logic [31:0] en,
                       input logic [31:0] bs, input logic [31:0] fl,
                       input logic [31:0] cs);
        @(negedge clk);
        now_chk(tag, en, bs, fl, cs);
    endtask

    task automatic fetch();
        stp("T0", E_MAR | E_Z, B_PC, F_RUN, A_INC);
        stp("T1a", E_PC | E_MDR, B_ZLO, F_MDRD | F_RD | F_RUN, 0);
        stp("T1b", E_MDR, 0, F_MDRD | F_RD | F_RUN, 0);
        stp("T2", E_IR, B_MDR, F_RUN, 0);
    endtask

    task automatic end_instr();
`ifdef CTRL_SINGLE_STEP_EN
        stp("swait", 0, 0, F_RUN, 0);
`endif
    endtask

    task automatic br_seq(input logic cf);
        ir = 32'h9800_0000;
        con_ff = cf;
        fetch();
        stp("br.T3", E_CON, 0, F_GRA | F_ROUT | F_RUN, 0);
        stp("br.T4", E_Y, B_PC, F_RUN, 0);
        stp("br.T5", E_Z, B_C, F_RUN, A_ADD);
        if (cf) stp("br1.T6", E_PC, B_ZLO, F_RUN, 0);
        else    stp("br0.T6", 0, 0, F_RUN, 0);
        end_instr();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: no summary after 200000 time units");
        $fatal(1);
    end

    initial begin
        clr = 1'b0;
        ir = 32'h1891_8000;
        con_ff = 1'b0;
`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b1;
`endif
        repeat (2) @(negedge clk);
        stp("rst", 0, 0, F_RUN, 0);
        clr = 1'b1;

        fetch();
        stp("add.T3", E_Y, 0, F_GRB | F_ROUT | F_RUN, 0);
        stp("add.T4", E_Z, 0, F_GRC | F_ROUT | F_RUN, A_ADD);
        stp("add.T5", 0, B_ZLO, F_GRA | F_RIN | F_RUN, 0);
        end_instr();

        br_seq(1'b0);
        br_seq(1'b1);
        con_ff = 1'b0;

        ir = 32'h0090_0005;
        fetch();
        stp("ld.T3", E_Y, 0, F_GRB | F_BA | F_RUN, 0);
        stp("ld.T4", E_Z, B_C, F_RUN, A_ADD);
        stp("ld.T5", E_MAR, B_ZLO, F_RUN, 0);
        stp("ld.T6a", E_MDR, 0, F_MDRD | F_RD | F_RUN, 0);
        stp("ld.T6b", E_MDR, 0, F_MDRD | F_RD | F_RUN, 0);
        stp("ld.T7", 0, B_MDR, F_GRA | F_RIN | F_RUN, 0);
        end_instr();

        ir = 32'h1090_0005;
        fetch();
        stp("st.T3", E_Y, 0, F_GRB | F_BA | F_RUN, 0);
        stp("st.T4", E_Z, B_C, F_RUN, A_ADD);
        stp("st.T5", E_MAR, B_ZLO, F_RUN, 0);
        stp("st.T6", E_MDR, 0, F_GRA | F_ROUT | F_RUN, 0);
        stp("st.T7a", 0, 0, F_WR | F_RUN, 0);
        stp("st.T7b", 0, 0, F_WR | F_RUN, 0);
        end_instr();

        ir = 32'h7891_8000;
        fetch();
        stp("mul.T3", E_Y, 0, F_GRA | F_ROUT | F_RUN, 0);
        stp("mul.T4", E_Z, 0, F_GRB | F_ROUT | F_RUN, A_MUL);
        stp("mul.T5", E_LO, B_ZLO, F_RUN, 0);
        stp("mul.T6", E_HI, B_ZHI, F_RUN, 0);
        end_instr();

        ir = 32'hA891_8000;
        fetch();
        stp("jal.T3", 0, B_PC, F_GRB | F_RIN | F_RUN, 0);
        stp("jal.T4", E_PC, 0, F_GRA | F_ROUT | F_RUN, 0);
        end_instr();

        ir = 32'hD000_0000;
        fetch();
        stp("nop.T3", 0, 0, F_RUN, 0);
        end_instr();

`ifdef CTRL_SINGLE_STEP_EN
        step = 1'b0;
        fetch();
        stp("nop2.T3", 0, 0, F_RUN, 0);
        for (int i = 0; i < 10; i++) stp("hold", 0, 0, F_RUN, 0);
        step = 1'b1;
`endif

        ir = 32'h1891_8000;
        fetch();
        stp("abort.T3", E_Y, 0, F_GRB | F_ROUT | F_RUN, 0);
        stp("abort.T4", E_Z, 0, F_GRC | F_ROUT | F_RUN, A_ADD);
        #2 clr = 1'b0;
        #1 now_chk("abort", 0, 0, F_RUN, 0);
        @(negedge clk);
        clr = 1'b1;

        ir = 32'hD800_0000;
        fetch();
        stp("halt.T3", 0, 0, F_RUN, 0);
        for (int i = 0; i < 20; i++) stp("halt", 0, 0, 0, 0);
        clr = 1'b0;
        #1 now_chk("unhalt", 0, 0, F_RUN, 0);
        @(negedge clk);
        clr = 1'b1;
        ir = 32'h1891_8000;
        fetch();
        stp("post.T3", E_Y, 0, F_GRB | F_ROUT | F_RUN, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
